// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep controller: FSM state codes
// (these values are shown on db_estado) and default timing constants.
package sonar_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    ESPERA_SERVO   = 4'h1,
    MEDE           = 4'h2,
    AGUARDA_MEDIDA = 4'h3,
    TIMEOUT        = 4'h4,
    TRANSMITE      = 4'h5,
    AGUARDA_ENVIO  = 4'h6,
    PROXIMA        = 4'h7
  } state_t;

  localparam int unsigned T_SETTLE_DEFAULT  = 50_000_000;
  localparam int unsigned T_TIMEOUT_DEFAULT = 2_500_000;

  // Width of the shared settle/timeout timer; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sweep_position_gen.sv
// Servo position generator: holds posicao/sentido and performs one ping-pong
// step per i_avanca pulse. Endpoints are visited once per pass
// (0,1,..,N_POS-1,N_POS-2,..,0,1,...).
// Ports:
//   i_clock    system clock, rising edge
//   i_reset    asynchronous, active-low
//   i_avanca   1 = take one step this cycle
//   o_posicao  current position, 0..N_POS-1
//   o_sentido  1 = ascending, 0 = descending
module sweep_position_gen #(
  parameter int unsigned N_POS = 8,
  parameter int unsigned PW    = 3
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_avanca,
  output logic [PW-1:0] o_posicao,
  output logic          o_sentido
);

  localparam logic [PW-1:0] LAST_POS = PW'(N_POS - 1);

  logic [PW-1:0] r_posicao;
  logic          r_sentido;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_posicao <= '0;
      r_sentido <= 1'b1;
    end else if (i_avanca) begin
      if (r_sentido) begin
        if (r_posicao == LAST_POS) begin
          r_posicao <= r_posicao - 1'b1;
          r_sentido <= 1'b0;
        end else begin
          r_posicao <= r_posicao + 1'b1;
        end
      end else begin
        if (r_posicao == '0) begin
          r_posicao <= r_posicao + 1'b1;
          r_sentido <= 1'b1;
        end else begin
          r_posicao <= r_posicao - 1'b1;
        end
      end
    end
  end

  assign o_posicao = r_posicao;
  assign o_sentido = r_sentido;

endmodule

// File: rtl/sonar_sweep_controller.sv
// Sonar scan sequencer. For each servo angle: wait T_SETTLE cycles, pulse
// medir, wait for medida_pronto (bounded by T_TIMEOUT), pulse transmitir and
// wait for envio_pronto, then pulse fim_posicao and step the ping-pong sweep.
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low
//   ligar          level, 1 = sweep enabled
//   parar          level, 1 = abort (highest priority)
//   medida_pronto  pulse from FD: distance valid
//   envio_pronto   pulse from FD: serial frame done
//   medir          pulse: start measurement
//   transmitir     pulse: start serial transmission
//   posicao        current servo position
//   sentido        1 = ascending sweep
//   fim_posicao    pulse: angle finished (sent or timed out)
//   timeout        pulse: echo timeout at current angle
//   db_estado      FSM state code
module sonar_sweep_controller
  import sonar_pkg::*;
#(
  parameter int unsigned N_POS     = 8,
  parameter int unsigned T_SETTLE  = T_SETTLE_DEFAULT,
  parameter int unsigned T_TIMEOUT = T_TIMEOUT_DEFAULT,
  parameter int unsigned PW        = $clog2(N_POS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ligar,
  input  logic          parar,
  input  logic          medida_pronto,
  input  logic          envio_pronto,
  output logic          medir,
  output logic          transmitir,
  output logic [PW-1:0] posicao,
  output logic          sentido,
  output logic          fim_posicao,
  output logic          timeout,
  output logic [3:0]    db_estado
);

  localparam int unsigned TW = timer_width(T_SETTLE, T_TIMEOUT);
  localparam logic [TW-1:0] SETTLE_LAST  = TW'(T_SETTLE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(T_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic          w_timer_run;
  logic          w_pulse_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= INICIAL;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      INICIAL:        if (ligar) w_state_next = ESPERA_SERVO;
      ESPERA_SERVO:   if (r_timer == SETTLE_LAST) w_state_next = MEDE;
      MEDE:           w_state_next = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA: begin
        // A measurement arriving on the last timeout cycle still counts.
        if (medida_pronto)                w_state_next = TRANSMITE;
        else if (r_timer == TIMEOUT_LAST) w_state_next = TIMEOUT;
      end
      TIMEOUT:        w_state_next = PROXIMA;
      TRANSMITE:      w_state_next = AGUARDA_ENVIO;
      AGUARDA_ENVIO:  if (envio_pronto) w_state_next = PROXIMA;
      PROXIMA:        w_state_next = ligar ? ESPERA_SERVO : INICIAL;
      default:        w_state_next = INICIAL;
    endcase
    if (parar) w_state_next = INICIAL;
  end

  // Timer runs only while staying in a waiting state; any state change
  // (including an abort) clears it. It saturates instead of wrapping.
  always_comb begin
    w_timer_run  = ((r_state == ESPERA_SERVO) || (r_state == AGUARDA_MEDIDA))
                   && (w_state_next == r_state);
    w_timer_next = '0;
    if (w_timer_run) w_timer_next = (r_timer == '1) ? r_timer : r_timer + 1'b1;
  end

  // An abort cycle emits no pulse and leaves the sweep position untouched.
  assign w_pulse_en  = ~parar;
  assign medir       = w_pulse_en & (r_state == MEDE);
  assign transmitir  = w_pulse_en & (r_state == TRANSMITE);
  assign timeout     = w_pulse_en & (r_state == TIMEOUT);
  assign fim_posicao = w_pulse_en & (r_state == PROXIMA);
  assign db_estado   = r_state;

  sweep_position_gen #(
    .N_POS (N_POS),
    .PW    (PW)
  ) u_position (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_avanca  (fim_posicao),
    .o_posicao (posicao),
    .o_sentido (sentido)
  );

endmodule
